// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI device end of the dual-channel ADC link, shifting two sample words out on MISO.
// CS/SCK are synchronized into clk, edge-detected, and drive a WAIT_IDLE/IDLE/SHIFT state machine.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_ni,
  input  logic              spi_sck_i,
  output logic [1:0]        spi_miso_o,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              sample_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              frame_err_o
);
  localparam int FRAME = LEAD_ZEROS + DATA_W;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t           r_state, w_next;
  logic             w_cs, w_sck, r_cs_prev, r_sck_prev;
  logic             w_cs_fall, w_cs_rise, w_sck_fall, w_sck_rise, w_start, w_end;
  logic [FRAME-1:0] r_shift0, r_shift1;
  logic [CW-1:0]    r_rise_cnt;
  logic             r_sample, r_done, r_err;

  // Sync flops reset low so a CS held low across reset never looks like a fresh fall.
  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] r_cs_s, r_sck_s;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_cs_s  <= '0;
        r_sck_s <= '0;
      end else begin
        r_cs_s  <= (r_cs_s << 1) | SYNC_STAGES'(spi_cs_ni);
        r_sck_s <= (r_sck_s << 1) | SYNC_STAGES'(spi_sck_i);
      end
    assign w_cs  = r_cs_s[SYNC_STAGES-1];
    assign w_sck = r_sck_s[SYNC_STAGES-1];
  end else begin : g_nosync
    assign w_cs  = spi_cs_ni;
    assign w_sck = spi_sck_i;
  end

  assign w_cs_fall  = r_cs_prev & ~w_cs;
  assign w_cs_rise  = ~r_cs_prev & w_cs;
  assign w_sck_fall = r_sck_prev & ~w_sck;
  assign w_sck_rise = ~r_sck_prev & w_sck;
  assign w_start    = (r_state == IDLE) && w_cs_fall;
  assign w_end      = (r_state == SHIFT) && w_cs_rise;

  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_IDLE: w_next = w_cs ? IDLE : WAIT_IDLE;
      IDLE:      w_next = w_cs_fall ? SHIFT : IDLE;
      SHIFT:     w_next = w_cs_rise ? IDLE : SHIFT;
      default:   w_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= WAIT_IDLE;
      r_cs_prev  <= 1'b0;
      r_sck_prev <= 1'b0;
      r_shift0   <= '0;
      r_shift1   <= '0;
      r_rise_cnt <= '0;
      r_sample   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cs_prev  <= w_cs;
      r_sck_prev <= w_sck;
      r_sample   <= w_start;
      r_done     <= w_end && (r_rise_cnt == CW'(FRAME));
      r_err      <= w_end && (r_rise_cnt != CW'(FRAME));
      if (w_start) begin
        r_shift0   <= {{LEAD_ZEROS{1'b0}}, data0_i};
        r_shift1   <= {{LEAD_ZEROS{1'b0}}, data1_i};
        r_rise_cnt <= '0;
      end else if (r_state == SHIFT && !w_cs_rise) begin
        if (w_sck_fall) begin
          r_shift0 <= r_shift0 << 1;
          r_shift1 <= r_shift1 << 1;
        end
        if (w_sck_rise && r_rise_cnt != CW'(FRAME))
          r_rise_cnt <= r_rise_cnt + 1'b1;
      end
    end

  assign busy_o       = (r_state == SHIFT);
  assign spi_miso_o   = busy_o ? {r_shift1[FRAME-1], r_shift0[FRAME-1]} : 2'b00;
  assign sample_o     = r_sample;
  assign frame_done_o = r_done;
  assign frame_err_o  = r_err;
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: drives SPI frames as a master and checks MISO bits and pulses against a frame-word model.
module tb_spi_adc_responder;
  localparam int H = 5;

  logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b1, sck = 1'b0;
  logic [11:0] d0 = '0, d1 = '0;
  logic [1:0]  miso;
  logic        sample, busy, done, err;
  int checks = 0, errors = 0, n_sample = 0, n_done = 0, n_err = 0;

  spi_adc_responder dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_ni(cs), .spi_sck_i(sck), .spi_miso_o(miso),
    .data0_i(d0), .data1_i(d1), .sample_o(sample), .busy_o(busy),
    .frame_done_o(done), .frame_err_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sample) n_sample++;
    if (done) n_done++;
    if (err) n_err++;
  end

  task automatic run_frame(input logic [11:0] a, input logic [11:0] b, input int nr,
                           input logic chg, input logic [11:0] na, input string nm);
    logic [31:0] g0 = '0, g1 = '0, e0 = '0, e1 = '0, m = '0;
    logic [15:0] w0 = {4'b0, a}, w1 = {4'b0, b};
    int s0 = n_sample, sd = n_done, se = n_err;
    d0 = a;
    d1 = b;
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || n_sample - s0 !== 1)
      begin errors++; $display("FAIL %s start: busy=%b samples=%0d, want busy=1 samples=1", nm, busy, n_sample - s0); end
    for (int k = 0; k < nr; k++) begin
      g0[k] = miso[0];
      g1[k] = miso[1];
      e0[k] = (k < 16) ? w0[15-k] : 1'b0;
      e1[k] = (k < 16) ? w1[15-k] : 1'b0;
      m[k]  = 1'b1;
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
      repeat (H) @(negedge clk);
      if (chg && k == 4) d0 = na;
    end
    cs = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ((g0 & m) !== e0)
      begin errors++; $display("FAIL %s miso0: got %h want %h (%0d bits)", nm, g0 & m, e0, nr); end
    checks++;
    if ((g1 & m) !== e1)
      begin errors++; $display("FAIL %s miso1: got %h want %h (%0d bits)", nm, g1 & m, e1, nr); end
    checks++;
    if (n_done - sd !== (nr >= 16 ? 1 : 0) || n_err - se !== (nr >= 16 ? 0 : 1) || n_sample - s0 !== 1)
      begin errors++; $display("FAIL %s pulses: done=%0d err=%0d sample=%0d, want done=%0d err=%0d sample=1",
                               nm, n_done - sd, n_err - se, n_sample - s0, nr >= 16 ? 1 : 0, nr >= 16 ? 0 : 1); end
    checks++;
    if (miso !== 2'b00 || busy !== 1'b0)
      begin errors++; $display("FAIL %s idle: miso=%b busy=%b, want 00/0", nm, miso, busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (miso !== 2'b00 || sample !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL reset: miso=%b sample=%b busy=%b done=%b err=%b, want all 0", miso, sample, busy, done, err); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(12'hA5C, 12'h3F1, 16, 1'b0, 12'h000, "t1_frame");
    run_frame(12'hFFF, 12'h001, 16, 1'b0, 12'h000, "fff_001");
  endtask

  task automatic test_short_frame();
    run_frame(12'hABC, 12'h555, 9, 1'b0, 12'h000, "short9");
    run_frame(12'h9E7, 12'h18C, 16, 1'b0, 12'h000, "after_short");
  endtask

  task automatic test_midframe_change();
    run_frame(12'h123, 12'h0F0, 16, 1'b1, 12'h456, "chg_cur");
    run_frame(12'h456, 12'h0F0, 16, 1'b0, 12'h000, "chg_next");
  endtask

  task automatic test_async_reset();
    logic [1:0] seen = '0;
    int s0, sd, se;
    d0 = 12'hFFF;
    d1 = 12'hFFF;
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
      repeat (H) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (miso !== 2'b00 || busy !== 1'b0)
      begin errors++; $display("FAIL async_reset: miso=%b busy=%b, want 00/0", miso, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_sample; sd = n_done; se = n_err;
    for (int k = 0; k < 10; k++) begin
      sck = 1'b1;
      repeat (H) @(negedge clk);
      seen |= miso;
      sck = 1'b0;
      repeat (H) @(negedge clk);
      seen |= miso;
    end
    checks++;
    if (seen !== 2'b00 || busy !== 1'b0 || n_sample != s0 || n_done != sd || n_err != se)
      begin errors++; $display("FAIL post_reset_cs_low: miso_or=%b busy=%b pulses=%0d, want 00/0/0",
                               seen, busy, (n_sample - s0) + (n_done - sd) + (n_err - se)); end
    cs = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (n_done != sd || n_err != se)
      begin errors++; $display("FAIL post_reset_cs_rise: pulses done=%0d err=%0d, want 0/0", n_done - sd, n_err - se); end
    run_frame(12'h6D2, 12'hB19, 16, 1'b0, 12'h000, "after_reset");
  endtask

  task automatic test_long_frame();
    run_frame(12'hFFF, 12'hFFF, 20, 1'b0, 12'h000, "long20");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_frame(12'($urandom), 12'($urandom), int'($urandom_range(1, 20)), 1'b0, 12'h000, "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_frame();
    test_midframe_change();
    test_async_reset();
    test_long_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
